// File: rtl/gb_lcd_tx.sv
// Game Boy LCD transmit: 2-bit pixel stream in, fixed-timing pixel clock/sync/data out.
// A small FIFO decouples the PPU from LCD timing; starvation is flagged, never waited out.
module gb_lcd_tx #(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 160,
  parameter int H_TOTAL    = 228,
  parameter int HS_START   = 164,
  parameter int HS_WIDTH   = 8,
  parameter int V_ACTIVE   = 144,
  parameter int V_TOTAL    = 154,
  parameter int VS_WIDTH   = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       lcd_on,
  input  logic [1:0] px_data,
  input  logic       px_sof,
  input  logic       px_valid,
  output logic       px_ready,
  output logic       gb_pclk,
  output logic       gb_de,
  output logic       gb_hsync,
  output logic       gb_vsync,
  output logic [1:0] gb_pixel,
  output logic       frame_done,
  output logic       underrun,
  output logic       sync_err
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV / 2);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
  localparam logic [7:0]    H_ACT     = 8'(H_ACTIVE);
  localparam logic [7:0]    H_LAST    = 8'(H_TOTAL - 1);
  localparam logic [7:0]    HS_BEG    = 8'(HS_START);
  localparam logic [7:0]    HS_END    = 8'(HS_START + HS_WIDTH);
  localparam logic [7:0]    V_ACT     = 8'(V_ACTIVE);
  localparam logic [7:0]    V_LAST    = 8'(V_TOTAL - 1);
  localparam logic [7:0]    VS_BEG    = 8'(V_ACTIVE);
  localparam logic [7:0]    VS_END    = 8'(V_ACTIVE + VS_WIDTH);

  typedef enum logic {IDLE, RUN} state_e;

  // ---------------- divider ----------------
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          gb_pclk_q, gb_pclk_d;
  logic          tick;

  assign tick = (div_cnt_q == DIV_LAST);

  // ---------------- FIFO ----------------
  logic [2:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, flush;
  logic          fifo_empty;
  logic          head_sof;
  logic [1:0]    head_data;

  assign px_ready   = lcd_on && (count_q < FIFO_FULL);
  assign push       = px_valid && px_ready;
  assign fifo_empty = (count_q == '0);
  assign head_sof   = fifo_mem[rd_ptr_q][2];
  assign head_data  = fifo_mem[rd_ptr_q][1:0];

  always_ff @(posedge pclk) begin
    if (push) fifo_mem[wr_ptr_q] <= {px_sof, px_data};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // ---------------- timing FSM ----------------
  state_e     state_q, state_d;
  logic [7:0] h_q, h_d, v_q, v_d;
  logic [7:0] h_nxt, v_nxt;
  logic       de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic [1:0] pix_q, pix_d;
  logic       frame_done_q, frame_done_d;
  logic       underrun_q, underrun_d;
  logic       sync_err_q, sync_err_d;
  logic       slot_de, slot_hs, slot_vs, slot_top, slot_last;
  logic       emit, abort;

  // h_q/v_q name the slot being emitted on the coming tick; both stay 0 in IDLE.
  assign slot_de   = (v_q < V_ACT) && (h_q < H_ACT);
  assign slot_hs   = (h_q >= HS_BEG) && (h_q < HS_END);
  assign slot_vs   = (v_q >= VS_BEG) && (v_q < VS_END);
  assign slot_top  = (h_q == 8'd0) && (v_q == 8'd0);
  assign slot_last = (h_q == H_ACT - 8'd1) && (v_q == V_ACT - 8'd1);
  assign h_nxt     = (h_q == H_LAST) ? 8'd0 : h_q + 8'd1;
  assign v_nxt     = (h_q != H_LAST) ? v_q : ((v_q == V_LAST) ? 8'd0 : v_q + 8'd1);

  always_comb begin
    div_cnt_d    = div_cnt_q;
    gb_pclk_d    = gb_pclk_q;
    state_d      = state_q;
    h_d          = h_q;
    v_d          = v_q;
    de_d         = de_q;
    hs_d         = hs_q;
    vs_d         = vs_q;
    pix_d        = pix_q;
    frame_done_d = 1'b0;
    underrun_d   = underrun_q;
    sync_err_d   = sync_err_q;
    pop          = 1'b0;
    flush        = 1'b0;
    emit         = 1'b0;
    abort        = 1'b0;
    if (!lcd_on) begin
      div_cnt_d  = '0;
      gb_pclk_d  = 1'b0;
      state_d    = IDLE;
      h_d        = 8'd0;
      v_d        = 8'd0;
      de_d       = 1'b0;
      hs_d       = 1'b0;
      vs_d       = 1'b0;
      pix_d      = 2'd0;
      underrun_d = 1'b0;
      sync_err_d = 1'b0;
      flush      = 1'b1;
    end else begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      gb_pclk_d = (div_cnt_d >= DIV_HALF);
      if (tick) begin
        de_d  = 1'b0;
        hs_d  = 1'b0;
        vs_d  = 1'b0;
        pix_d = 2'd0;
        // IDLE drains stale pixels until a frame start reaches the head.
        emit = (state_q == RUN) || (!fifo_empty && head_sof);
        if (state_q == IDLE && !fifo_empty && !head_sof) pop = 1'b1;
        if (emit) begin
          if (slot_de) begin
            if (fifo_empty) begin
              underrun_d = 1'b1;
            end else if (head_sof != slot_top) begin
              // A late sof is kept at the head so IDLE restarts on it next tick.
              sync_err_d = 1'b1;
              abort      = 1'b1;
              pop        = !head_sof;
            end else begin
              pop   = 1'b1;
              pix_d = head_data;
            end
          end
          if (abort) begin
            state_d = IDLE;
            h_d     = 8'd0;
            v_d     = 8'd0;
          end else begin
            state_d      = RUN;
            de_d         = slot_de;
            hs_d         = slot_hs;
            vs_d         = slot_vs;
            frame_done_d = slot_last;
            h_d          = h_nxt;
            v_d          = v_nxt;
          end
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      gb_pclk_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      h_q          <= 8'd0;
      v_q          <= 8'd0;
      de_q         <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      pix_q        <= 2'd0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      gb_pclk_q    <= gb_pclk_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      h_q          <= h_d;
      v_q          <= v_d;
      de_q         <= de_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      pix_q        <= pix_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign gb_pclk    = gb_pclk_q;
  assign gb_de      = de_q;
  assign gb_hsync   = hs_q;
  assign gb_vsync   = vs_q;
  assign gb_pixel   = pix_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_gb_lcd_tx.sv
// Scoreboard bench for gb_lcd_tx on a shrunken frame (8x4 active, 14x6 total).
// Pushes record expected pixels; a monitor compares each gb_pclk rising sample.
module tb_gb_lcd_tx;
  localparam int DIV = 4, H_A = 8, H_T = 14, HS_S = 9, HS_W = 2;
  localparam int V_A = 4, V_T = 6, VS_W = 1, DEPTH = 16;

  logic       pclk = 1'b0;
  logic       rst_n, lcd_on, px_sof, px_valid, px_ready;
  logic [1:0] px_data, gb_pixel;
  logic       gb_pclk, gb_de, gb_hsync, gb_vsync, frame_done, underrun, sync_err;

  typedef struct packed {logic rs; logic [1:0] pix;} exp_t;
  exp_t exp_q[$];
  int   tests = 0, fails = 0, fd_cnt = 0;
  logic mon_en = 1'b0;

  always #5 pclk = ~pclk;

  gb_lcd_tx #(
    .CLK_DIV(DIV), .H_ACTIVE(H_A), .H_TOTAL(H_T), .HS_START(HS_S), .HS_WIDTH(HS_W),
    .V_ACTIVE(V_A), .V_TOTAL(V_T), .VS_WIDTH(VS_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .lcd_on(lcd_on), .px_data(px_data), .px_sof(px_sof),
    .px_valid(px_valid), .px_ready(px_ready), .gb_pclk(gb_pclk), .gb_de(gb_de),
    .gb_hsync(gb_hsync), .gb_vsync(gb_vsync), .gb_pixel(gb_pixel),
    .frame_done(frame_done), .underrun(underrun), .sync_err(sync_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired, %0d expected entries left", name, exp_q.size());
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic push(input logic [1:0] d, input logic s, input logic rs);
    int   n = 0;
    exp_t e;
    px_data  = d;
    px_sof   = s;
    px_valid = 1'b1;
    while (!px_ready && n < 2000) begin
      @(negedge pclk);
      n++;
    end
    if (!px_ready) timeout("push_ready");
    e.pix = d;
    e.rs  = rs;
    exp_q.push_back(e);
    @(negedge pclk);
    px_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge pclk);
      n++;
    end
    if (exp_q.size() != 0) timeout(name);
  endtask

  task automatic monitor();
    logic prev = 1'b0, run = 1'b0;
    int   h = 0, v = 0;
    logic xde, xhs, xvs;
    exp_t e;
    forever begin
      @(negedge pclk);
      if (!mon_en) begin
        run = 1'b0;
      end else if (gb_pclk && !prev) begin
        if (!run && gb_de) begin
          run = 1'b1;
          h   = 0;
          v   = 0;
        end
        if (!run) begin
          chk("idle_outputs", int'({gb_hsync, gb_vsync, gb_pixel}), 0);
        end else begin
          xde = (v < V_A) && (h < H_A);
          xhs = (h >= HS_S) && (h < HS_S + HS_W);
          xvs = (v >= V_A) && (v < V_A + VS_W);
          if (xde && exp_q.size() != 0 && exp_q[0].rs) begin
            chk("resync_slot_low", int'({gb_de, gb_hsync, gb_vsync, gb_pixel}), 0);
            exp_q[0].rs = 1'b0;
            run = 1'b0;
          end else begin
            chk($sformatf("timing h%0d v%0d", h, v), int'({gb_de, gb_hsync, gb_vsync}),
                int'({xde, xhs, xvs}));
            if (xde) begin
              if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pixel h%0d v%0d: de slot with no expected pixel", h, v);
              end else begin
                e = exp_q.pop_front();
                chk($sformatf("pixel h%0d v%0d", h, v), int'(gb_pixel), int'(e.pix));
              end
            end
            h++;
            if (h == H_T) begin
              h = 0;
              v = (v == V_T - 1) ? 0 : v + 1;
            end
          end
        end
      end
      prev = gb_pclk;
    end
  endtask

  task automatic fd_count();
    forever begin
      @(negedge pclk);
      if (frame_done) fd_cnt++;
    end
  endtask

  initial begin
    int   n, fd0;
    exp_t z;
    rst_n = 1'b0; lcd_on = 1'b0; px_valid = 1'b0; px_data = 2'd0; px_sof = 1'b0;
    fork
      monitor();
      fd_count();
    join_none

    // reset state
    repeat (3) @(negedge pclk);
    chk("reset_outputs", int'({gb_pclk, gb_de, gb_hsync, gb_vsync, gb_pixel, frame_done,
                               underrun, sync_err}), 0);
    chk("ready_lcd_off", int'(px_ready), 0);
    rst_n = 1'b1;
    @(negedge pclk);
    lcd_on = 1'b1;
    #1 chk("ready_on", int'(px_ready), 1);
    @(negedge pclk);

    // fill FIFO with non-sof entries (IDLE drains one per tick)
    px_data = 2'd1; px_sof = 1'b0; px_valid = 1'b1;
    n = 0;
    while (px_ready && n < 100) begin @(negedge pclk); n++; end
    chk("fifo_full_ready", int'(px_ready), 0);
    px_valid = 1'b0;
    n = 0;
    while (!px_ready && n < 20) begin @(negedge pclk); n++; end
    chk("pop_from_full", int'(px_ready), 1);
    repeat (3) @(negedge pclk);
    px_valid = 1'b1;
    @(negedge pclk);
    chk("push_pop_at_15", int'(px_ready), 1);
    @(negedge pclk);
    chk("refull_after_push", int'(px_ready), 0);
    px_valid = 1'b0;
    lcd_on = 1'b0;
    @(negedge pclk);
    chk("ready_lcd_dropped", int'(px_ready), 0);
    chk("pclk_held_low", int'(gb_pclk), 0);
    lcd_on = 1'b1;
    #1 chk("flushed_ready", int'(px_ready), 1);
    @(negedge pclk);

    // two clean frames back to back
    fd0 = fd_cnt; mon_en = 1'b1;
    for (int i = 0; i < 64; i++) push(2'(i), (i % 32) == 0, 1'b0);
    wait_empty("two_frames_drain");
    mon_en = 1'b0;
    chk("frame_done_two", fd_cnt - fd0, 2);
    chk("no_underrun", int'(underrun), 0);
    chk("no_sync_err", int'(sync_err), 0);
    lcd_on = 1'b0;
    repeat (2) @(negedge pclk);
    lcd_on = 1'b1;
    @(negedge pclk);

    // misplaced sof at pixel 3 of line 1 restarts the frame from it
    fd0 = fd_cnt; mon_en = 1'b1;
    for (int i = 0; i < 43; i++) push(2'(i), (i == 0) || (i == 11), i == 11);
    wait_empty("resync_drain");
    chk("sync_err_set", int'(sync_err), 1);
    chk("frame_done_resync", fd_cnt - fd0, 1);
    chk("resync_no_underrun", int'(underrun), 0);

    // next frame, dropped mid-line by lcd_on
    for (int i = 0; i < 16; i++) push(2'(i + 2), i == 0, 1'b0);
    n = 0;
    while (exp_q.size() > 4 && n < 4000) begin @(negedge pclk); n++; end
    if (exp_q.size() > 4) timeout("midline_reach");
    chk("sync_err_sticky", int'(sync_err), 1);
    mon_en = 1'b0;
    lcd_on = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge pclk);
    chk("off_outputs", int'({gb_pclk, gb_de, gb_hsync, gb_vsync, gb_pixel, frame_done,
                             underrun, sync_err}), 0);
    chk("off_ready", int'(px_ready), 0);

    // clean frame after re-enable
    lcd_on = 1'b1;
    @(negedge pclk);
    fd0 = fd_cnt; mon_en = 1'b1;
    for (int i = 0; i < 32; i++) push(2'(3 - (i % 4)), i == 0, 1'b0);
    wait_empty("reenable_drain");
    mon_en = 1'b0;
    chk("frame_done_reenable", fd_cnt - fd0, 1);
    chk("reenable_no_underrun", int'(underrun), 0);
    chk("reenable_no_sync_err", int'(sync_err), 0);
    lcd_on = 1'b0;
    repeat (2) @(negedge pclk);
    lcd_on = 1'b1;
    @(negedge pclk);

    // starve after 5 pixels: remaining de slots carry 0, timing continues
    fd0 = fd_cnt; mon_en = 1'b1;
    for (int i = 0; i < 5; i++) push(2'(i + 1), i == 0, 1'b0);
    z.pix = 2'd0;
    z.rs  = 1'b0;
    for (int i = 0; i < 27; i++) exp_q.push_back(z);
    wait_empty("starve_drain");
    chk("underrun_set", int'(underrun), 1);
    chk("frame_done_starved", fd_cnt - fd0, 1);
    chk("starve_no_sync_err", int'(sync_err), 0);
    mon_en = 1'b0;

    // asynchronous reset while running
    repeat (5) @(negedge pclk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", int'({gb_pclk, gb_de, gb_hsync, gb_vsync, gb_pixel,
                                        frame_done, underrun, sync_err}), 0);
    repeat (3) @(negedge pclk);
    rst_n = 1'b1;
    @(negedge pclk);
    chk("ready_after_reset", int'(px_ready), 1);
    chk("idle_after_reset", int'({gb_de, gb_hsync, gb_vsync, gb_pixel, underrun, sync_err}), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gb_lcd_tx.md
Name: gb_lcd_tx

Overview:
Transmit side of the Game Boy LCD pixel interface. Accepts 2-bit PPU pixels over a valid/ready stream into a small FIFO and serialises them as gb_pclk/gb_de/gb_hsync/gb_vsync/gb_pixel with fixed 160x144 frame timing. Its output drives the capture side of the video buffer directly. Timing never stalls: FIFO underrun is flagged, not waited out.

Parameters:
CLK_DIV, 4, pclk cycles per gb_pclk period; even, >=2
H_ACTIVE, 160, active pixels per line
H_TOTAL, 228, pixel slots per line
HS_START, 164, h slot where gb_hsync rises
HS_WIDTH, 8, gb_hsync width in slots
V_ACTIVE, 144, active lines per frame
V_TOTAL, 154, lines per frame
VS_WIDTH, 1, gb_vsync width in lines, starting at line V_ACTIVE
FIFO_DEPTH, 16, input FIFO entries; power of two

Ports:
pclk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
lcd_on  in  1  enable; low = flush and idle
px_data  in  2  pixel shade
px_sof  in  1  marks first pixel of a frame
px_valid  in  1  pixel offered
px_ready  out  1  pixel accepted when valid&ready
gb_pclk  out  1  LCD pixel clock
gb_de  out  1  active-pixel enable
gb_hsync  out  1  line sync, active high
gb_vsync  out  1  frame sync, active high
gb_pixel  out  2  pixel to LCD
frame_done  out  1  one-pclk pulse at end of last active pixel slot
underrun  out  1  sticky: pixel slot with empty FIFO
sync_err  out  1  sticky: sof misplaced

Behaviour:
- Reset (rst_n low, async): all outputs 0, FIFO empty, state IDLE, counters 0.
- Divider: div_cnt 0..CLK_DIV-1 free-runs while lcd_on; tick = (div_cnt==CLK_DIV-1). gb_pclk = 1 when div_cnt >= CLK_DIV/2, else 0. gb_de/hsync/vsync/pixel change only on the pclk edge after tick; they are stable across the following gb_pclk rising edge.
- FIFO: push on px_valid&px_ready; entry = {sof,data}. px_ready = lcd_on & (count<FIFO_DEPTH), with count registered; no push when full, even if a pop occurs in the same cycle. Simultaneous push and pop leaves count unchanged.
- States:
  - IDLE: outputs low; h_cnt/v_cnt held at 0. Non-sof head entries are popped and discarded, one per tick. When the head has sof on a tick, go to RUN. That tick is slot h=0/v=0 and pops the head.
  - RUN: each tick advances h_cnt. At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments. At the end of line V_TOTAL-1, v_cnt wraps to 0.
    - gb_de = (v<V_ACTIVE)&(h<H_ACTIVE).
    - gb_hsync = HS_START<=h<HS_START+HS_WIDTH, on all lines.
    - gb_vsync = V_ACTIVE<=v<V_ACTIVE+VS_WIDTH, across full lines.
    - On each de slot, pop one entry and drive its data on gb_pixel. On non-de slots, drive gb_pixel 0.
- Underrun: de slot with FIFO empty drives gb_pixel=0, sets underrun, and timing continues.
- Sof checking:
  - Popped entry at h=0,v=0 of a new frame without sof: set sync_err, drop it, go IDLE.
  - Popped entry with sof at any other slot: set sync_err, go IDLE. That entry stays at the head for resync and is not consumed.
- frame_done: pulses on the tick of slot (H_ACTIVE-1, V_ACTIVE-1).
- lcd_on low (any time, including mid-frame): the next pclk flushes the FIFO, state goes IDLE, and all outputs go 0. underrun and sync_err clear. Sticky flags otherwise clear only on reset.
- Counter widths: h 8 bits, v 8 bits, count clog2(FIFO_DEPTH)+1 bits.

Test Plan:
- Reset mid-RUN (rst_n low 3 cycles) -> all outputs 0 asynchronously, px_ready=1 after release with lcd_on=1.
- Push 23040 pixels (sof on first, data=idx%4), default params -> exactly 23040 gb_de rising-gb_pclk samples matching data in order, 154 lines of 228 slots, one gb_vsync pulse 228 slots long at line 144, frame_done once.
- Starve FIFO after 100 pixels of line 0 -> underrun=1, gb_pixel=0 from slot 100, gb_hsync still at slot 164 every line.
- Inject sof at pixel 50 of line 3 -> sync_err=1, outputs low next tick, next frame starts from that sof with vsync timing restarted.
- Fill FIFO to 16 with no ticks -> px_ready=0. Push+pop same cycle at count 15 -> count stays 15.
- Deassert lcd_on mid-line -> FIFO flushed, flags cleared, gb_pclk held 0. Re-enable with sof -> clean frame.
